// File: rtl/tail_light_seq.sv
// Rear-lamp sequencer: progressive turn fill, hazard flash and brake overlay,
// stepping once per DIV clocks. Outputs are decoded from the next state and registered.
module tail_light_seq #(
    parameter int LAMPS = 3,
    parameter int DIV   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         direction,
    input  logic               brake,
    output logic [2*LAMPS-1:0] lamps,
    output logic               busy
);
    localparam int IDX_W = $clog2(LAMPS + 1);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, RIGHT, LEFT, HAZ_ON, HAZ_OFF} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*LAMPS-1:0] lamps_q, lamps_d;
    logic               busy_q, busy_d;

    logic               tick;
    logic               sample;
    logic [LAMPS-1:0]   right_fill, left_fill, side_on;

    always_comb begin
        tick    = (cnt_q == CNT_W'(DIV - 1));
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        sample  = 1'b0;
        state_d = state_q;
        idx_d   = idx_q;

        if (tick) begin
            case (state_q)
                IDLE, HAZ_OFF: sample = 1'b1;
                RIGHT, LEFT: begin
                    if (idx_q == IDX_W'(LAMPS)) sample = 1'b1;
                    else                        idx_d  = idx_q + IDX_W'(1);
                end
                HAZ_ON:  state_d = HAZ_OFF;
                default: state_d = IDLE;
            endcase
        end

        // Direction is only looked at between sequences, so a running one always completes
        if (sample) begin
            idx_d = '0;
            case (direction)
                2'b01:   state_d = RIGHT;
                2'b10:   state_d = LEFT;
                2'b11:   state_d = HAZ_ON;
                default: state_d = IDLE;
            endcase
        end

        right_fill = '0;
        left_fill  = '0;
        for (int i = 0; i < LAMPS; i++) begin
            right_fill[i] = (int'(idx_d) < LAMPS) && (i + int'(idx_d) >= LAMPS - 1);
            left_fill[i]  = (int'(idx_d) < LAMPS) && (i <= int'(idx_d));
        end
        side_on = {LAMPS{brake}};

        case (state_d)
            RIGHT:   lamps_d = {side_on, right_fill};
            LEFT:    lamps_d = {left_fill, side_on};
            HAZ_ON:  lamps_d = '1;
            HAZ_OFF: lamps_d = '0;
            default: lamps_d = {2*LAMPS{brake}};
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            lamps_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lamps_q <= lamps_d;
            busy_q  <= busy_d;
        end
    end

    assign lamps = lamps_q;
    assign busy  = busy_q;
endmodule
